fifo_rr_sched: RTL and testbench
================================

Name: fifo_rr_sched

Overview:
- Round-robin burst scheduler that drains N first-word-fall-through (FWFT) FIFOs onto one shared valid/ready output stream.
- Sits between per-source FIFO instances and a single downstream consumer, e.g. a DMA or serializer.
- Grants one channel at a time for a burst of up to MAX_BURST words, then rotates priority.
- Drives each FIFO's rd directly; no internal data storage.

Parameters:
- N, 4, number of requesting FIFOs (2..16)
- WIDTH, 32, data width of every FIFO and of the output
- MAX_BURST, 8, maximum words per grant (1..256)

Ports:
- clk  input  1  clock
- rst  input  1  reset
- fifo_empty  input  N  per-channel FWFT empty flag; bit i=0 means fifo_dout[i] is valid
- fifo_dout  input  N*WIDTH  per-channel FWFT head word; channel i occupies bits [i*WIDTH +: WIDTH]
- fifo_rd  output  N  per-channel pop strobe, one-hot or zero
- out_vld  output  1  output word valid
- out_rdy  input  1  downstream accepts word
- out_data  output  WIDTH  selected head word
- out_ch  output  CH_W  channel index of out_data
- out_last  output  1  final beat of the current burst
- busy  output  1  state != IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Values after reset:
  - state=IDLE, grant=0, last_grant=N-1, so ch0 has first priority.
  - beat_cnt=0.
  - All outputs 0: out_vld=0, fifo_rd=0, busy=0, out_last=0.
- Widths:
  - CH_W = max(1, $clog2(N)).
  - beat_cnt width = $clog2(MAX_BURST+1).
  - Round-robin index arithmetic wraps modulo N, not modulo 2^CH_W.
- State IDLE:
  - out_vld=0.
  - If any fifo_empty bit is 0, grant the first non-empty channel searching last_grant+1, last_grant+2, ... (wrapping).
  - On a grant: register grant, set last_grant=grant, clear beat_cnt, go to BURST.
  - Costs one arbitration bubble cycle per burst.
- State BURST, combinational outputs:
  - out_vld = ~fifo_empty[grant].
  - out_data = fifo_dout[grant].
  - out_ch = grant.
  - out_last = out_vld & (beat_cnt == MAX_BURST-1).
  - fifo_rd[grant] = out_vld & out_rdy; all other fifo_rd bits are 0.
- State BURST, transitions:
  - Transfer (out_vld & out_rdy): beat_cnt++. If out_last, go to IDLE.
  - fifo_empty[grant]=1 with no transfer: burst ends early, go to IDLE.
  - out_vld=1 with out_rdy=0: hold everything; out_data stable; grant never revoked while a word is offered.
- Boundary conditions:
  - Never assert fifo_rd on an empty channel.
  - Never assert more than one fifo_rd bit.
  - Channel that empties at the exact moment its last word transfers: next cycle sees empty, goes to IDLE, no spurious pop.
  - MAX_BURST=1: every transfer is out_last, giving strict per-word round-robin.
  - Single active channel: it is re-granted every burst, with one bubble cycle between bursts.
  - rst mid-burst: immediately returns to reset values. Any word offered that cycle is not popped.
- Throughput: MAX_BURST words per MAX_BURST+1 cycles under continuous load.

Optional Feature:
- Macro: FIFO_RR_SCHED_STATS_EN
- Defined:
  - Adds output stat_beats (N*32): a per-channel count of transferred words.
  - Counters saturate at 32'hFFFF_FFFF.
  - Counters clear on rst.
  - Adds input stat_clr (1): synchronous clear of all counters; a transfer in the same cycle is not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_rr_sched_pkg holds:
  - typedef sched_state_t enum {IDLE, BURST}
  - function clog2_min1 (used to derive CH_W)
  - STAT_W=32 constant
- Sub-module rr_pick (parameter N): inputs req[N] and last[CH_W]; outputs any and idx[CH_W]. It is purely combinational, with a rotate-priority search. It is reusable by other arbiters in the codebase.
- Top level holds the FSM, beat counter, output mux and optional stats.

Test Plan:
- Reset, then ch2 only non-empty holding 3 words, out_rdy=1:
  - One bubble cycle after rst deasserts.
  - out_ch=2 for data words 0xA0,0xA1,0xA2 on consecutive cycles.
  - No out_last, since 3 < MAX_BURST.
  - Returns to IDLE on empty.
- All 4 channels hold 20 words each, out_rdy=1, MAX_BURST=8:
  - Bursts in order ch0,1,2,3,0,... of 8 beats each.
  - out_last on beat 8.
  - 80 words total, each channel's data in FIFO order.
- Backpressure: out_rdy toggles at random (50%) during a burst on ch1:
  - out_data and out_ch are stable while out_vld & ~out_rdy.
  - fifo_rd[1] fires only on handshake cycles.
  - Exactly 8 pops per burst.
- Round-robin fairness: last_grant=1, with ch0 and ch3 non-empty:
  - The next grant is ch3, then ch0.
- rst asserted in BURST at beat 4 with out_rdy=0:
  - Next cycle busy=0 and out_vld=0, with no fifo_rd pulse.
  - After reset, ch0 has priority.
- With FIFO_RR_SCHED_STATS_EN, 5 words from ch1 then stat_clr pulsed concurrently with a 6th transfer:
  - stat_beats[1] reads 5 before the clear.
  - It reads 0 after the clear; the concurrent transfer is not counted.

Source files
------------

// File: rtl/fifo_rr_sched_pkg.sv
// Shared types and helpers for the FIFO round-robin burst scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   STAT_W        width of each per-channel beat counter
//   sched_state_t scheduler FSM encoding
//   clog2_min1()  index width that never collapses to zero bits
package fifo_rr_sched_pkg;

    localparam int STAT_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    // A one-channel build still needs a 1-bit channel index.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_rr_sched_if.sv
// Bundle of per-channel FWFT FIFO read signals plus the shared output stream.
// Latency: n/a (wiring only).
// Backpressure: out_rdy from the consumer; fifo_rd pops the granted FIFO.
//
// Signals:
//   fifo_empty [N]        per-channel FWFT empty flag (0 = head word valid)
//   fifo_dout  [N*WIDTH]  per-channel head word, channel i at [i*WIDTH +: WIDTH]
//   fifo_rd    [N]        per-channel pop strobe, one-hot or zero
//   out_vld/out_rdy       output stream handshake
//   out_data/out_ch       selected word and its source channel
//   out_last              final beat of the current burst
// Modports: master = scheduler side, slave = FIFO/consumer side.
interface fifo_rr_sched_if
    import fifo_rr_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int CH_W = clog2_min1(N);

    logic [N-1:0]       fifo_empty;
    logic [N*WIDTH-1:0] fifo_dout;
    logic [N-1:0]       fifo_rd;
    logic               out_vld;
    logic               out_rdy;
    logic [WIDTH-1:0]   out_data;
    logic [CH_W-1:0]    out_ch;
    logic               out_last;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_rdy,
        output fifo_rd,
        output out_vld,
        output out_data,
        output out_ch,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_rdy,
        input  fifo_rd,
        input  out_vld,
        input  out_data,
        input  out_ch,
        input  out_last
    );

endinterface

// File: rtl/fifo_rr_sched_rr_pick.sv
// Rotating-priority picker: first requester after 'last', wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the pick.
//
// Ports:
//   req  [N]     request vector
//   last [CH_W]  most recently served index; search starts at last+1
//   any          at least one request present
//   idx  [CH_W]  chosen index (0 when any=0)
module rr_pick
    import fifo_rr_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int CH_W = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] last,
    output logic            any,
    output logic [CH_W-1:0] idx
);

    // base+k wraps at N, not at 2**CH_W, so non-power-of-two N never
    // produces an index past the last real channel. base < N and k <= N,
    // so one conditional subtraction is enough.
    function automatic logic [CH_W-1:0] nth_after(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return CH_W'(s);
    endfunction

    // k = 1 is the highest priority (the channel right after 'last');
    // k = N wraps back to 'last' itself, so a lone requester is re-granted.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[nth_after(last, k)]) begin
                any = 1'b1;
                idx = nth_after(last, k);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin burst scheduler draining N FWFT FIFOs onto one valid/ready stream.
// Latency: one arbitration bubble per burst, then one word per cycle (combinational data path).
// Backpressure: out_rdy low holds grant, data and beat count; fifo_rd only pops on a handshake.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bus         fifo_rr_sched_if.master (FIFO read side + output stream)
//   busy        scheduler is inside a burst
// Optional (FIFO_RR_SCHED_STATS_EN defined):
//   stat_clr    synchronous clear of all beat counters
//   stat_beats  N x 32-bit saturating per-channel transferred-word counters
module fifo_rr_sched
    import fifo_rr_sched_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rr_sched_if.master      bus,
`ifdef FIFO_RR_SCHED_STATS_EN
    input  logic                 stat_clr,
    output logic [N*STAT_W-1:0]  stat_beats,
`endif
    output logic                 busy
);

    localparam int CH_W = clog2_min1(N);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N - 1);
    localparam logic [N-1:0]    CH0_BIT   = N'(1);

    sched_state_t    state;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] last_grant;
    logic [BC_W-1:0] beat_cnt;

    logic            pick_any;
    logic [CH_W-1:0] pick_idx;
    logic [N-1:0]    req_vec;

    logic            in_burst;
    logic            cur_vld;
    logic            xfer;
    logic            is_last;
    logic [N-1:0]    rd_vec;

    logic [WIDTH-1:0] dout_arr [N];

    // ---------------------------------------------------------------
    // Head-word unpack so the output mux indexes by channel directly.
    // ---------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign dout_arr[i] = bus.fifo_dout[i*WIDTH +: WIDTH];
    end

    // ---------------------------------------------------------------
    // Arbitration: search starts just after the last granted channel.
    // ---------------------------------------------------------------
    assign req_vec = ~bus.fifo_empty;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req  (req_vec),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // ---------------------------------------------------------------
    // Output path. Valid is suppressed while rst is high so a word that
    // happens to be on offer during the reset cycle is neither accepted
    // downstream nor popped from its FIFO.
    // ---------------------------------------------------------------
    assign in_burst = (state == BURST);
    assign cur_vld  = in_burst && !bus.fifo_empty[grant] && !rst;
    assign xfer     = cur_vld && bus.out_rdy;
    assign is_last  = cur_vld && (beat_cnt == LAST_BEAT);

    // Only the granted channel can ever pop, and only on a handshake,
    // which also guarantees the channel was non-empty.
    assign rd_vec   = xfer ? (CH0_BIT << grant) : '0;

    assign bus.out_vld  = cur_vld;
    assign bus.out_data = in_burst ? dout_arr[grant] : '0;
    assign bus.out_ch   = grant;
    assign bus.out_last = is_last;
    assign bus.fifo_rd  = rd_vec;
    assign busy         = in_burst;

    // ---------------------------------------------------------------
    // Scheduler FSM. last_grant resets to N-1 so channel 0 is searched
    // first. The grant is only released when the granted FIFO runs dry
    // without a transfer or when the final beat is accepted, so an
    // offered word is never withdrawn under backpressure.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_CH;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        beat_cnt   <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (is_last) begin
                            state <= IDLE;
                        end
                    end else if (bus.fifo_empty[grant]) begin
                        // Source ran dry mid-burst: give others a turn.
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_RR_SCHED_STATS_EN
    // ---------------------------------------------------------------
    // Per-channel transferred-word counters. Clear wins over a
    // concurrent transfer; counters stick at all-ones.
    // ---------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_stat
        logic [STAT_W-1:0] beats_q;

        always_ff @(posedge clk) begin
            if (rst || stat_clr) begin
                beats_q <= '0;
            end else if (rd_vec[i] && (beats_q != {STAT_W{1'b1}})) begin
                beats_q <= beats_q + 1'b1;
            end
        end

        assign stat_beats[i*STAT_W +: STAT_W] = beats_q;
    end
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched with behavioural FWFT FIFO models.
// Latency: n/a (testbench).
// Backpressure: out_rdy driven directly by the stimulus sequence.
module tb_fifo_rr_sched;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int MB    = 8;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [3:0]       ch;
        logic [WIDTH-1:0] data;
        logic             last;
    } xfer_t;

    logic clk;
    logic rst;
    logic busy;
`ifdef FIFO_RR_SCHED_STATS_EN
    logic                stat_clr;
    logic [N*32-1:0]     stat_beats;
`endif

    fifo_rr_sched_if #(.N(N), .WIDTH(WIDTH)) bus ();

    fifo_rr_sched #(
        .N         (N),
        .WIDTH     (WIDTH),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef FIFO_RR_SCHED_STATS_EN
        .stat_clr   (stat_clr),
        .stat_beats (stat_beats),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] q [N][$];
    xfer_t            xlog [$];
    logic [N-1:0]     rd_seen;
    int               cycle;
    int               n_checks;
    int               n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present every model FIFO's head word and empty flag to the DUT.
    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus.fifo_empty[i] = (q[i].size() == 0);
            bus.fifo_dout[i*WIDTH +: WIDTH] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] d);
        q[ch].push_back(d);
        refresh();
    endtask

    // One clock: sample the settled pop strobes and handshake, clock,
    // then pop the model FIFOs the DUT strobed.
    task automatic cyc();
        logic [N-1:0] exp_rd;
        logic [N-1:0] one;
        #1;
        rd_seen = bus.fifo_rd;
        one     = 1;
        exp_rd  = (bus.out_vld && bus.out_rdy) ? (one << bus.out_ch) : '0;
        check("rd_vs_handshake", rd_seen, exp_rd);
        check("rd_on_empty", rd_seen & bus.fifo_empty, 0);
        if (bus.out_vld && bus.out_rdy)
            xlog.push_back('{cyc: cycle, ch: 4'(bus.out_ch), data: bus.out_data, last: bus.out_last});
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (rd_seen[i] && q[i].size() != 0) void'(q[i].pop_front());
        refresh();
        cycle++;
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 100 && (busy !== 1'b0); k++) cyc();
        check(tag, busy, 0);
    endtask

    function automatic logic [63:0] pk(input logic [3:0] ch, input logic [WIDTH-1:0] d, input logic l);
        return 64'({ch, d, l});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               held;
        logic [WIDTH-1:0] hold_data;
        logic [1:0]       hold_ch;
        int               r, m, ch, j, w;

        n_checks = 0;
        n_errors = 0;
        cycle    = 0;
        rst      = 1'b1;
        bus.out_rdy = 1'b0;
`ifdef FIFO_RR_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        refresh();
        repeat (2) @(posedge clk);
        #2;

        // ---------------- Reset values ----------------
        check("rst_busy", busy, 0);
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_fifo_rd", bus.fifo_rd, 0);
        check("rst_out_last", bus.out_last, 0);

        // ---------------- T1: ch2 alone, 3 words ----------------
        push(2, 32'hA0); push(2, 32'hA1); push(2, 32'hA2);
        cyc();
        check("t1_vld_in_rst", bus.out_vld, 0);
        xlog.delete();
        bus.out_rdy = 1'b1;
        rst = 1'b0;
        #1;
        check("t1_bubble", bus.out_vld, 0);
        cyc();
        check("t1_b0", {bus.out_vld, busy, pk(4'(bus.out_ch), bus.out_data, bus.out_last)},
              {2'b11, pk(2, 32'hA0, 0)});
        cyc();
        check("t1_b1", pk(4'(bus.out_ch), bus.out_data, bus.out_last), pk(2, 32'hA1, 0));
        cyc();
        check("t1_b2", pk(4'(bus.out_ch), bus.out_data, bus.out_last), pk(2, 32'hA2, 0));
        cyc();
        check("t1_empty_vld", bus.out_vld, 0);
        check("t1_empty_busy", busy, 1);
        cyc();
        check("t1_idle", busy, 0);
        check("t1_count", xlog.size(), 3);
        if (xlog.size() == 3) check("t1_consecutive", xlog[2].cyc - xlog[0].cyc, 2);

        // ---------------- T2: 4 channels x 20 words ----------------
        rst = 1'b1;
        cyc();
        for (int c = 0; c < N; c++)
            for (int k = 0; k < 20; k++) push(c, 32'h1000 * (c + 1) + k);
        xlog.delete();
        rst = 1'b0;
        for (int k = 0; k < 300 && xlog.size() < 80; k++) cyc();
        check("t2_count", xlog.size(), 80);
        if (xlog.size() == 80) begin
            for (int n = 0; n < 80; n++) begin
                if (n < 64) begin
                    r = n / 32; m = n % 32; ch = m / 8; j = n % 8; w = r * 8 + j;
                end else begin
                    m = n - 64; ch = m / 4; j = m % 4; w = 16 + j;
                end
                check($sformatf("t2_xfer%0d", n),
                      pk(xlog[n].ch, xlog[n].data, xlog[n].last),
                      pk(4'(ch), 32'h1000 * (ch + 1) + w, (n < 64) && (j == 7)));
            end
            check("t2_throughput", xlog[63].cyc - xlog[0].cyc, 70);
        end
        wait_idle("t2_idle");

        // ---------------- T3: backpressure on ch1 ----------------
        for (int k = 0; k < 10; k++) push(1, 32'h3000 + k);
        xlog.delete();
        held = 1'b0;
        hold_data = '0;
        hold_ch = '0;
        for (int k = 0; k < 300 && xlog.size() < 10; k++) begin
            bus.out_rdy = 1'($urandom_range(0, 1));
            if (held) begin
                check("t3_hold_vld", bus.out_vld, 1);
                check("t3_hold_data", bus.out_data, hold_data);
                check("t3_hold_ch", bus.out_ch, hold_ch);
            end
            held      = bus.out_vld && !bus.out_rdy;
            hold_data = bus.out_data;
            hold_ch   = bus.out_ch;
            cyc();
        end
        check("t3_count", xlog.size(), 10);
        if (xlog.size() == 10) begin
            for (int n = 0; n < 10; n++)
                check($sformatf("t3_xfer%0d", n), pk(xlog[n].ch, xlog[n].data, xlog[n].last),
                      pk(1, 32'h3000 + n, n == 7));
            check("t3_rearb_gap", (xlog[8].cyc - xlog[7].cyc) >= 2, 1);
        end
        check("t3_drained", q[1].size(), 0);
        bus.out_rdy = 1'b1;
        wait_idle("t3_idle");

        // ---------------- T4: fairness after ch1 served ----------------
        push(0, 32'hD0); push(0, 32'hD1);
        push(3, 32'hE0); push(3, 32'hE1);
        xlog.delete();
        for (int k = 0; k < 50 && xlog.size() < 4; k++) cyc();
        check("t4_count", xlog.size(), 4);
        if (xlog.size() == 4) begin
            check("t4_x0", pk(xlog[0].ch, xlog[0].data, xlog[0].last), pk(3, 32'hE0, 0));
            check("t4_x1", pk(xlog[1].ch, xlog[1].data, xlog[1].last), pk(3, 32'hE1, 0));
            check("t4_x2", pk(xlog[2].ch, xlog[2].data, xlog[2].last), pk(0, 32'hD0, 0));
            check("t4_x3", pk(xlog[3].ch, xlog[3].data, xlog[3].last), pk(0, 32'hD1, 0));
        end
        wait_idle("t4_idle");

        // ---------------- T5: reset mid-burst ----------------
        rst = 1'b1;
        cyc();
        for (int k = 0; k < 8; k++) push(2, 32'h50 + k);
        rst = 1'b0;
        cyc();                      // bubble
        repeat (4) cyc();           // beats 0..3
        check("t5_offer", {bus.out_vld, bus.out_data}, {1'b1, 32'h54});
        bus.out_rdy = 1'b0;
        rst = 1'b1;
        cyc();
        check("t5_busy", busy, 0);
        check("t5_vld", bus.out_vld, 0);
        check("t5_rd", rd_seen, 0);
        check("t5_no_pop", q[2].size(), 4);
        push(0, 32'h60);
        push(3, 32'h70);
        xlog.delete();
        bus.out_rdy = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 60 && xlog.size() < 6; k++) cyc();
        check("t5_count", xlog.size(), 6);
        if (xlog.size() == 6) begin
            check("t5_first", pk(xlog[0].ch, xlog[0].data, xlog[0].last), pk(0, 32'h60, 0));
            for (int n = 1; n < 5; n++)
                check($sformatf("t5_ch2_%0d", n), pk(xlog[n].ch, xlog[n].data, xlog[n].last),
                      pk(2, 32'h54 + n - 1, 0));
            check("t5_ch3", pk(xlog[5].ch, xlog[5].data, xlog[5].last), pk(3, 32'h70, 0));
        end
        wait_idle("t5_idle");

`ifdef FIFO_RR_SCHED_STATS_EN
        // ---------------- T6: stats counter and clear ----------------
        rst = 1'b1;
        cyc();
        check("t6_rst_clear", stat_beats[1*32 +: 32], 0);
        for (int k = 0; k < 6; k++) push(1, 32'h600 + k);
        xlog.delete();
        rst = 1'b0;
        for (int k = 0; k < 40 && xlog.size() < 5; k++) cyc();
        check("t6_five", stat_beats[1*32 +: 32], 5);
        check("t6_sixth_offered", bus.out_vld, 1);
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        check("t6_cleared", stat_beats[1*32 +: 32], 0);
        check("t6_sixth_done", xlog.size(), 6);
        wait_idle("t6_idle");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
